cv32e40x_xif_aes_unit: RTL

Parametrised AES32 (Zkne/Zknd saes32) coprocessor attached to the cv32e40x eXtension interface (issue/commit/result channels). It buffers up to `X_DEPTH` outstanding speculative instructions and computes each at issue. It holds each result until the core commits the instruction, drops killed ones, and returns results in issue order with back-pressure. It supersedes the single-shot saes32 wrapper: it adds a real handshake, commit tracking, queueing, an optional output register and a decrypt-disable mode.

---
 rtl/cv32e40x_xif_aes_unit.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cv32e40x_xif_aes_unit.sv
// cv32e40x_xif_aes_unit: saes32 (encs/encsm/decs/decsm) coprocessor on the
// eXtension interface. Each result is computed when the instruction is issued.
// It then waits in an in-order queue until the core commits or kills it, and
// committed results drain through the result channel in issue order.
module cv32e40x_xif_aes_unit #(
  parameter int unsigned X_ID_WIDTH  = 4,
  parameter int unsigned X_DEPTH     = 2,
  parameter bit          SAES_DEC_EN = 1'b1,
  parameter bit          OUT_REG     = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [31:0]           issue_instr,
  input  logic [X_ID_WIDTH-1:0] issue_id,
  input  logic [31:0]           issue_rs0,
  input  logic [31:0]           issue_rs1,
  input  logic [1:0]            issue_rs_valid,
  output logic                  issue_accept,
  output logic                  issue_writeback,
  input  logic                  commit_valid,
  input  logic [X_ID_WIDTH-1:0] commit_id,
  input  logic                  commit_kill,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [X_ID_WIDTH-1:0] result_id,
  output logic [31:0]           result_data,
  output logic [4:0]            result_rd,
  output logic                  result_we
);

  localparam int unsigned PW = (X_DEPTH > 1) ? $clog2(X_DEPTH) : 1;
  localparam int unsigned CW = $clog2(X_DEPTH) + 1;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [4:0]            rd;
    logic [31:0]           data;
    logic                  cmt;
    logic                  kill;
  } ent_t;

  // ---------------------------------------------------------------------------
  // GF(2^8) helpers (mod x^8+x^4+x^3+x+1). The S-boxes are built from the field
  // inverse plus the affine map rather than from a 256-entry table.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // a^254 == a^-1 for a != 0, and 0 maps to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = gmul(a, a);
    r  = sq;
    for (int i = 0; i < 6; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] b, input int unsigned n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = ginv(x);
    return v ^ rol8(v, 1) ^ rol8(v, 2) ^ rol8(v, 3) ^ rol8(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] s);
    return ginv(rol8(s, 1) ^ rol8(s, 3) ^ rol8(s, 6) ^ 8'h05);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(X_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  ent_t               ent_q [X_DEPTH];
  ent_t               ent_d [X_DEPTH];
  logic [X_DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]      rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic        is_aes, is_dec_op, is_mix, full, push, pop, load;
  logic [4:0]  f5;
  logic [1:0]  bs;
  logic [7:0]  xb, sb;
  logic [31:0] col, res;
  logic [63:0] dw;
  ent_t        head, out_ent;
  logic        head_vld, head_rdy, out_vld;

  logic unused_bits;
  assign unused_bits = ^{issue_instr[24:15], out_ent.cmt, out_ent.kill};

  // Decode and handshake: non-AES instructions are always acknowledged and declined
  always_comb begin
    f5        = issue_instr[29:25];
    is_dec_op = f5[2];
    is_mix    = f5[1];
    is_aes    = 1'b0;
    if (issue_instr[6:0] == 7'b0110011 && issue_instr[14:12] == 3'b000) begin
      if (f5 == 5'b10001 || f5 == 5'b10011)
        is_aes = 1'b1;
      else if (SAES_DEC_EN && (f5 == 5'b10101 || f5 == 5'b10111))
        is_aes = 1'b1;
    end
    full            = (cnt_q == CW'(X_DEPTH));
    // a pop in the same cycle never frees a slot for the incoming instruction
    issue_ready     = is_aes ? (!full && issue_rs_valid == 2'b11) : 1'b1;
    push            = issue_valid && issue_ready && is_aes;
    issue_accept    = push;
    issue_writeback = push;
  end

  // saes32 datapath: pick byte bs of rs2, substitute, optionally mix, rotate, xor key
  always_comb begin
    bs = issue_instr[31:30];
    xb = issue_rs1[{bs, 3'b000} +: 8];
    sb = is_dec_op ? isbox(xb) : sbox(xb);
    if (!is_mix)
      col = {24'b0, sb};
    else if (!is_dec_op)
      col = {gmul(sb, 8'h03), sb, sb, gmul(sb, 8'h02)};
    else
      col = {gmul(sb, 8'h0b), gmul(sb, 8'h0d), gmul(sb, 8'h09), gmul(sb, 8'h0e)};
    dw  = {col, col} << {bs, 3'b000};
    res = issue_rs0 ^ dw[63:32];
  end

  assign head     = ent_q[rptr_q];
  assign head_vld = vld_q[rptr_q];
  assign head_rdy = head_vld && head.cmt && !head.kill;

  if (OUT_REG) begin : g_oreg
    ent_t oreg_q, oreg_d;
    logic ovld_q, ovld_d;

    // Output stage refills in the same cycle its content is handed off
    always_comb begin
      load   = head_rdy && (!ovld_q || result_ready);
      ovld_d = load || (ovld_q && !result_ready);
      oreg_d = load ? head : oreg_q;
    end

    // Output stage register
    always_ff @(posedge clk) begin
      if (rst) begin
        ovld_q <= 1'b0;
        oreg_q <= '0;
      end else begin
        ovld_q <= ovld_d;
        oreg_q <= oreg_d;
      end
    end

    assign out_vld = ovld_q;
    assign out_ent = oreg_q;
  end else begin : g_direct
    assign load    = head_rdy && result_ready;
    assign out_vld = head_rdy;
    assign out_ent = head;
  end

  // Killed heads retire silently; committed heads retire when handed off
  assign pop = head_vld && (head.kill || load);

  // Queue update: commit/kill marking, push at write pointer, pop at read pointer
  always_comb begin
    ent_d  = ent_q;
    vld_d  = vld_q;
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    for (int i = 0; i < X_DEPTH; i++) begin
      if (commit_valid && vld_q[i] && ent_q[i].id == commit_id) begin
        if (commit_kill) ent_d[i].kill = 1'b1;
        else             ent_d[i].cmt  = 1'b1;
      end
    end
    if (pop) begin
      vld_d[rptr_q] = 1'b0;
      rptr_d        = ptr_inc(rptr_q);
    end
    if (push) begin
      // a commit naming the instruction issued this cycle lands on the new entry
      ent_d[wptr_q].id   = issue_id;
      ent_d[wptr_q].rd   = issue_instr[11:7];
      ent_d[wptr_q].data = res;
      ent_d[wptr_q].cmt  = commit_valid && !commit_kill && commit_id == issue_id;
      ent_d[wptr_q].kill = commit_valid &&  commit_kill && commit_id == issue_id;
      vld_d[wptr_q]      = 1'b1;
      wptr_d             = ptr_inc(wptr_q);
    end
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  // Queue control state; reset empties the queue and drops every entry
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Entry payload storage; only meaningful where the matching valid bit is set
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  assign result_valid = out_vld;
  assign result_we    = out_vld;
  assign result_id    = out_vld ? out_ent.id   : '0;
  assign result_rd    = out_vld ? out_ent.rd   : '0;
  assign result_data  = out_vld ? out_ent.data : '0;

endmodule
